// File: rtl/csr_test_monitor.sv
// Pass/fail monitor on the core's CSR write port: watches tohost, counts cycles,
// reports pass/fail/timeout and raises done after a drain period.
// Optional `define CSR_MON_CYCLE_CAPTURE_EN adds the result_cycle output.
module csr_test_monitor #(
  parameter int unsigned TIMEOUT_CYCLE = 100_000_000,
  parameter int unsigned ARM_DELAY     = 10,
  parameter int unsigned DRAIN_CYCLES  = 100,
  parameter logic [11:0] TOHOST_ADDR   = 12'h51E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] cycle_count
`ifdef CSR_MON_CYCLE_CAPTURE_EN
  ,
  output logic [31:0] result_cycle
`endif
);

  typedef enum logic [1:0] {S_ARM, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [31:0] ARM_LAST   = 32'(ARM_DELAY) - 32'd1;
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLE) - 32'd1;
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES) - 32'd1;

  state_e      state_q, state_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        timeout_q, timeout_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;
`ifdef CSR_MON_CYCLE_CAPTURE_EN
  logic [31:0] result_cycle_q, result_cycle_d;
`endif

  logic accept;
  logic tmo_hit;
  logic arm_done;
  logic drain_end;

  // Only the first non-zero tohost write seen in RUN counts; the FSM leaves RUN on it.
  assign accept    = (state_q == S_RUN) && csr_we && (csr_addr == TOHOST_ADDR)
                     && (csr_wdata != 32'd0);
  // A valid write in the timeout cycle takes priority over the timeout.
  assign tmo_hit   = (state_q == S_RUN) && (cycle_count_q == TMO_LAST) && !accept;
  assign arm_done  = (ARM_DELAY == 0) || (cycle_count_q == ARM_LAST);
  assign drain_end = (state_q == S_DRAIN) && (drain_cnt_q == DRAIN_LAST);

  // NOTE: every flop uses <= so all state updates see pre-edge values; the
  // asynchronous reset clears outputs immediately, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_ARM;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= 32'd0;
      cycle_count_q  <= 32'd0;
      drain_cnt_q    <= 32'd0;
`ifdef CSR_MON_CYCLE_CAPTURE_EN
      result_cycle_q <= 32'd0;
`endif
    end else begin
      state_q        <= state_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      timeout_q      <= timeout_d;
      done_q         <= done_d;
      result_q       <= result_d;
      cycle_count_q  <= cycle_count_d;
      drain_cnt_q    <= drain_cnt_d;
`ifdef CSR_MON_CYCLE_CAPTURE_EN
      result_cycle_q <= result_cycle_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ARM:   if (arm_done) state_d = S_RUN;
      S_RUN:   if (accept || tmo_hit) state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (drain_end) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_ARM;
    endcase
  end

  // NOTE: each comb output defaults to its held value first, so no latch is inferred.
  always_comb begin
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    result_d      = result_q;
    cycle_count_d = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
    drain_cnt_d   = (state_q == S_DRAIN) ? drain_cnt_q + 32'd1 : 32'd0;
    done_d        = done_q | (state_d == S_DONE);
`ifdef CSR_MON_CYCLE_CAPTURE_EN
    result_cycle_d = result_cycle_q;
`endif
    if (accept) begin
      result_d = csr_wdata;
      pass_d   = (csr_wdata == 32'd1);
      fail_d   = (csr_wdata != 32'd1);
    end
    if (tmo_hit) timeout_d = 1'b1;
`ifdef CSR_MON_CYCLE_CAPTURE_EN
    // Captures the cycle in which the verdict was sampled (write or timeout cycle).
    if (accept || tmo_hit) result_cycle_d = cycle_count_q;
`endif
  end

  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign done        = done_q;
  assign result      = result_q;
  assign cycle_count = cycle_count_q;
`ifdef CSR_MON_CYCLE_CAPTURE_EN
  assign result_cycle = result_cycle_q;
`endif

endmodule
